div_sequencer: RTL

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_pkg.sv | 13 +
 rtl/div_bit_counter.sv | 21 ++
 rtl/div_sequencer.sv | 76 +++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and width default for the division sequencer.
package div_pkg;
    localparam int DIV_WIDTH_DEFAULT = 8;
    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_LOAD    = 3'b001,
        S_SHIFT   = 3'b010,
        S_COMPARE = 3'b011,
        S_WRITE   = 3'b100,
        S_DONE    = 3'b101,
        S_ERR     = 3'b110
    } state_t;
endpackage

// File: rtl/div_bit_counter.sv
// div_bit_counter: loadable down-counter of remaining quotient bits; saturates at zero.
module div_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_zero
);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
    assign o_cnt  = r_cnt;
    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: Moore control FSM for a restoring shift/subtract divider.
// Define DIV_SEQ_ZERO_CHECK_EN to divert a zero divisor from LOAD to a one-cycle error done.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mayor,
    input  logic                       divisor_zero,
    output logic                       busy,
    output logic                       load,
    output logic                       bajar,
    output logic                       restar,
    output logic                       q_we,
    output logic                       q_bit,
    output logic                       done,
    output logic                       div_err,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);
    localparam int CW = $clog2(WIDTH+1);
    state_t        r_state, w_next;
    logic          r_qbit;
    logic [CW-1:0] w_cnt;
    logic          w_zero, w_last, w_zero_err;
`ifdef DIV_SEQ_ZERO_CHECK_EN
    assign w_zero_err = divisor_zero;
    assign div_err    = r_state == S_ERR;
`else
    logic w_unused_dz;
    assign w_unused_dz = divisor_zero;
    assign w_zero_err  = 1'b0;
    assign div_err     = 1'b0;
`endif
    div_bit_counter #(.CW(CW)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == S_LOAD),
        .i_load_val (CW'(WIDTH)),
        .i_dec      (r_state == S_WRITE),
        .o_cnt      (w_cnt),
        .o_zero     (w_zero)
    );
    assign w_last = w_cnt == CW'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_qbit  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_COMPARE) r_qbit <= mayor;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:    w_next = w_zero_err ? S_ERR : S_SHIFT;
            S_SHIFT:   w_next = S_COMPARE;
            S_COMPARE: w_next = S_WRITE;
            // a zero count here is impossible; treat it as the last bit rather than wrap
            S_WRITE:   w_next = (w_last || w_zero) ? S_DONE : S_SHIFT;
            default:   w_next = S_IDLE;
        endcase
    end
    assign busy    = r_state != S_IDLE;
    assign load    = r_state == S_LOAD;
    assign bajar   = r_state == S_SHIFT;
    assign q_we    = r_state == S_WRITE;
    assign q_bit   = q_we & r_qbit;
    assign restar  = q_bit;
    assign done    = r_state == S_DONE || r_state == S_ERR;
    assign bit_cnt = w_cnt;
endmodule
